// File: rtl/imsic_msi_ingress.sv
// imsic_msi_ingress
//   Ingress buffer between the SoC MSI write path and the per-hart IMSIC
//   interrupt files. MSI writes (file select + EIID) are filtered for
//   legality, buffered in a small FIFO and drained as one set-pending
//   request per cycle.
//
// Ports:
//   clk_i, rst_ni            clock, synchronous active-low reset
//   msi_valid_i/ready_o      MSI write handshake (ready = !full, no path from setip_ready_i)
//   msi_file_i, msi_eiid_i   target interrupt file and identity
//   setip_valid_o/ready_i    set-pending request handshake
//   setip_file_o/eiid_o      head entry payload
//   occ_o                    current FIFO occupancy
//   drop_cnt_o               saturating count of filtered (illegal) writes
//   drop_cnt_clr_i           synchronous clear of drop_cnt_o (wins over increment)
//
// Optional feature macro: IMSIC_MSI_COALESCE_EN
//   When defined, a legal write matching any buffered (file, eiid) entry is
//   consumed without being enqueued or counted.
module imsic_msi_ingress #(
  parameter int unsigned NrIntpFiles    = 3,
  parameter int unsigned NrSourcesImsic = 64,
  parameter int unsigned FifoDepth      = 4,
  parameter int unsigned FileW          = (NrIntpFiles > 1) ? $clog2(NrIntpFiles) : 1,
  parameter int unsigned CntW           = 16
) (
  input  logic                           clk_i,
  input  logic                           rst_ni,
  input  logic                           msi_valid_i,
  output logic                           msi_ready_o,
  input  logic [FileW-1:0]               msi_file_i,
  input  logic [10:0]                    msi_eiid_i,
  output logic                           setip_valid_o,
  input  logic                           setip_ready_i,
  output logic [FileW-1:0]               setip_file_o,
  output logic [10:0]                    setip_eiid_o,
  output logic [$clog2(FifoDepth):0]     occ_o,
  output logic [CntW-1:0]                drop_cnt_o,
  input  logic                           drop_cnt_clr_i
);

  localparam int unsigned PtrW = $clog2(FifoDepth);

  // Limits widened by one bit so the maximum legal parameter values still fit.
  localparam logic [11:0]    SrcLim  = 12'(NrSourcesImsic);
  localparam logic [FileW:0] FileLim = (FileW+1)'(NrIntpFiles);
  localparam logic [PtrW:0]  DepthV  = (PtrW+1)'(FifoDepth);

  logic [FileW-1:0] mem_file [FifoDepth];
  logic [10:0]      mem_eiid [FifoDepth];

  // Extra wrap bit distinguishes full from empty.
  logic [PtrW:0] wr_ptr, rd_ptr;
  logic [PtrW:0] occ;
  logic          full;
  logic          accept, illegal, dup, push, pop;

  assign occ     = wr_ptr - rd_ptr;
  assign full    = (occ == DepthV);
  assign occ_o   = occ;

  assign msi_ready_o   = rst_ni && !full;
  assign setip_valid_o = (occ != '0);
  assign setip_file_o  = mem_file[rd_ptr[PtrW-1:0]];
  assign setip_eiid_o  = mem_eiid[rd_ptr[PtrW-1:0]];

  assign accept  = msi_valid_i && msi_ready_o;
  assign illegal = (msi_eiid_i == '0)
                || ({1'b0, msi_eiid_i} >= SrcLim)
                || ({1'b0, msi_file_i} >= FileLim);

`ifdef IMSIC_MSI_COALESCE_EN
  // Match against entries present at the start of the cycle; an entry being
  // popped this cycle still counts, since its pending bit is set regardless.
  always_comb begin
    logic [PtrW-1:0] offs;
    dup  = 1'b0;
    offs = '0;
    for (int unsigned i = 0; i < FifoDepth; i++) begin
      offs = PtrW'(i) - rd_ptr[PtrW-1:0];
      if (({1'b0, offs} < occ) &&
          (mem_file[i] == msi_file_i) && (mem_eiid[i] == msi_eiid_i))
        dup = 1'b1;
    end
  end
`else
  assign dup = 1'b0;
`endif

  assign push = accept && !illegal && !dup;
  assign pop  = setip_valid_o && setip_ready_i;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      for (int unsigned i = 0; i < FifoDepth; i++) begin
        mem_file[i] <= '0;
        mem_eiid[i] <= '0;
      end
    end else begin
      if (push) begin
        mem_file[wr_ptr[PtrW-1:0]] <= msi_file_i;
        mem_eiid[wr_ptr[PtrW-1:0]] <= msi_eiid_i;
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop)
        rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni)
      drop_cnt_o <= '0;
    else if (drop_cnt_clr_i)
      drop_cnt_o <= '0;
    else if (accept && illegal && (drop_cnt_o != '1))
      drop_cnt_o <= drop_cnt_o + 1'b1;
  end

`ifndef SYNTHESIS
  a_no_push_full: assert property (@(posedge clk_i) disable iff (!rst_ni)
    push |-> !full);
  a_no_pop_empty: assert property (@(posedge clk_i) disable iff (!rst_ni)
    pop |-> (occ != '0));
  a_stall_stable: assert property (@(posedge clk_i) disable iff (!rst_ni)
    (setip_valid_o && !setip_ready_i) |=>
      ($stable(setip_file_o) && $stable(setip_eiid_o)));
`endif

endmodule

// File: tb/tb_imsic_msi_ingress.sv
// Directed testbench for imsic_msi_ingress (default parameters:
// 3 interrupt files, 64 sources, depth 4). Inputs change and outputs are
// checked 1ns after the rising edge.
module tb_imsic_msi_ingress;

  logic        clk = 1'b0;
  logic        rst_ni;
  logic        msi_valid;
  logic        msi_ready;
  logic [1:0]  msi_file;
  logic [10:0] msi_eiid;
  logic        setip_valid;
  logic        setip_ready;
  logic [1:0]  setip_file;
  logic [10:0] setip_eiid;
  logic [2:0]  occ;
  logic [15:0] drop_cnt;
  logic        drop_cnt_clr;

  int tests = 0;
  int fails = 0;

  imsic_msi_ingress #(
    .NrIntpFiles    (3),
    .NrSourcesImsic (64),
    .FifoDepth      (4),
    .CntW           (16)
  ) dut (
    .clk_i          (clk),
    .rst_ni         (rst_ni),
    .msi_valid_i    (msi_valid),
    .msi_ready_o    (msi_ready),
    .msi_file_i     (msi_file),
    .msi_eiid_i     (msi_eiid),
    .setip_valid_o  (setip_valid),
    .setip_ready_i  (setip_ready),
    .setip_file_o   (setip_file),
    .setip_eiid_o   (setip_eiid),
    .occ_o          (occ),
    .drop_cnt_o     (drop_cnt),
    .drop_cnt_clr_i (drop_cnt_clr)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_ni = 1'b0; msi_valid = 1'b1; msi_file = 2'd1; msi_eiid = 11'd5;
    setip_ready = 1'b0; drop_cnt_clr = 1'b0;
    for (int c = 0; c < 2; c++) begin
      tick();
      tests++; if (msi_ready !== 1'b0) begin fails++; $display("FAIL reset_ready cyc%0d got %b exp 0", c, msi_ready); end
      tests++; if (setip_valid !== 1'b0) begin fails++; $display("FAIL reset_valid cyc%0d got %b exp 0", c, setip_valid); end
      tests++; if (occ !== 3'd0) begin fails++; $display("FAIL reset_occ cyc%0d got %0d exp 0", c, occ); end
    end
    tests++; if (drop_cnt !== 16'd0) begin fails++; $display("FAIL reset_drop got %0d exp 0", drop_cnt); end
    rst_ni = 1'b1; msi_valid = 1'b0;
    #1;
    tests++; if (msi_ready !== 1'b1) begin fails++; $display("FAIL post_reset_ready got %b exp 1", msi_ready); end
    tick();
    tests++; if (setip_valid !== 1'b0) begin fails++; $display("FAIL post_reset_valid got %b exp 0", setip_valid); end
  endtask

  task automatic test_single();
    setip_ready = 1'b0;
    msi_valid = 1'b1; msi_file = 2'd1; msi_eiid = 11'd5;
    #1;
    tests++; if (setip_valid !== 1'b0) begin fails++; $display("FAIL single_nobypass got %b exp 0", setip_valid); end
    tick();
    msi_valid = 1'b0;
    tests++; if (setip_valid !== 1'b1) begin fails++; $display("FAIL single_valid got %b exp 1", setip_valid); end
    tests++; if (setip_file !== 2'd1) begin fails++; $display("FAIL single_file got %0d exp 1", setip_file); end
    tests++; if (setip_eiid !== 11'd5) begin fails++; $display("FAIL single_eiid got %0d exp 5", setip_eiid); end
    tests++; if (occ !== 3'd1) begin fails++; $display("FAIL single_occ got %0d exp 1", occ); end
    setip_ready = 1'b1;
    tick();
    tests++; if (setip_valid !== 1'b0) begin fails++; $display("FAIL single_drain_valid got %b exp 0", setip_valid); end
    tests++; if (occ !== 3'd0) begin fails++; $display("FAIL single_drain_occ got %0d exp 0", occ); end
    setip_ready = 1'b0;
  endtask

  task automatic test_full();
    logic [2:0] exp_occ [5];
    logic       exp_rdy [5];
    exp_occ = '{3'd4, 3'd3, 3'd3, 3'd2, 3'd1};
    exp_rdy = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
    setip_ready = 1'b0; msi_file = 2'd0;
    for (int k = 1; k <= 5; k++) begin
      msi_valid = 1'b1; msi_eiid = 11'(k);
      #1;
      if (k <= 4) begin
        tests++; if (msi_ready !== 1'b1) begin fails++; $display("FAIL full_fill_ready k%0d got %b exp 1", k, msi_ready); end
        tick();
      end else begin
        tests++; if (msi_ready !== 1'b0) begin fails++; $display("FAIL full_ready got %b exp 0", msi_ready); end
        tests++; if (occ !== 3'd4) begin fails++; $display("FAIL full_occ got %0d exp 4", occ); end
      end
    end
    // eiid 5 held valid; released ready drains 1..4, 5 enters when room opens
    setip_ready = 1'b1;
    for (int k = 1; k <= 5; k++) begin
      #1;
      tests++; if (setip_eiid !== 11'(k)) begin fails++; $display("FAIL full_order k%0d got %0d exp %0d", k, setip_eiid, k); end
      tests++; if (occ !== exp_occ[k-1]) begin fails++; $display("FAIL full_drain_occ k%0d got %0d exp %0d", k, occ, exp_occ[k-1]); end
      tests++; if (msi_ready !== exp_rdy[k-1]) begin fails++; $display("FAIL full_drain_ready k%0d got %b exp %b", k, msi_ready, exp_rdy[k-1]); end
      tick();
      if (k == 2) msi_valid = 1'b0;
    end
    tests++; if (occ !== 3'd0) begin fails++; $display("FAIL full_end_occ got %0d exp 0", occ); end
    setip_ready = 1'b0;
  endtask

  task automatic test_illegal();
    logic [1:0]  f [3];
    logic [10:0] e [3];
    f = '{2'd0, 2'd0, 2'd3};
    e = '{11'd0, 11'd64, 11'd5};
    setip_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      msi_valid = 1'b1; msi_file = f[k]; msi_eiid = e[k];
      #1;
      tests++; if (msi_ready !== 1'b1) begin fails++; $display("FAIL illegal_ready k%0d got %b exp 1", k, msi_ready); end
      tick();
      tests++; if (setip_valid !== 1'b0) begin fails++; $display("FAIL illegal_enq k%0d got %b exp 0", k, setip_valid); end
      tests++; if (occ !== 3'd0) begin fails++; $display("FAIL illegal_occ k%0d got %0d exp 0", k, occ); end
    end
    tests++; if (drop_cnt !== 16'd3) begin fails++; $display("FAIL drop_cnt got %0d exp 3", drop_cnt); end
    msi_file = 2'd0; msi_eiid = 11'd0; drop_cnt_clr = 1'b1;
    tick();
    drop_cnt_clr = 1'b0;
    tests++; if (drop_cnt !== 16'd0) begin fails++; $display("FAIL drop_clr_prio got %0d exp 0", drop_cnt); end
    msi_file = 2'd2; msi_eiid = 11'd63;
    tick();
    msi_valid = 1'b0;
    tests++; if (setip_valid !== 1'b1) begin fails++; $display("FAIL edge_legal_valid got %b exp 1", setip_valid); end
    tests++; if (setip_file !== 2'd2) begin fails++; $display("FAIL edge_legal_file got %0d exp 2", setip_file); end
    tests++; if (setip_eiid !== 11'd63) begin fails++; $display("FAIL edge_legal_eiid got %0d exp 63", setip_eiid); end
    tests++; if (drop_cnt !== 16'd0) begin fails++; $display("FAIL edge_legal_drop got %0d exp 0", drop_cnt); end
    tick();
    tests++; if (occ !== 3'd0) begin fails++; $display("FAIL edge_legal_drain got %0d exp 0", occ); end
    setip_ready = 1'b0;
  endtask

  task automatic test_back_to_back();
    setip_ready = 1'b0; msi_file = 2'd2;
    for (int k = 0; k < 2; k++) begin
      msi_valid = 1'b1; msi_eiid = 11'(10 + k);
      tick();
    end
    setip_ready = 1'b1;
    for (int c = 0; c < 10; c++) begin
      msi_valid = 1'b1; msi_eiid = 11'(12 + c);
      #1;
      tests++; if (occ !== 3'd2) begin fails++; $display("FAIL b2b_occ c%0d got %0d exp 2", c, occ); end
      tests++; if (setip_eiid !== 11'(10 + c)) begin fails++; $display("FAIL b2b_order c%0d got %0d exp %0d", c, setip_eiid, 10 + c); end
      tick();
    end
    msi_valid = 1'b0;
    for (int k = 0; k < 2; k++) begin
      tests++; if (setip_eiid !== 11'(20 + k)) begin fails++; $display("FAIL b2b_tail k%0d got %0d exp %0d", k, setip_eiid, 20 + k); end
      tick();
    end
    tests++; if (occ !== 3'd0) begin fails++; $display("FAIL b2b_end_occ got %0d exp 0", occ); end
    setip_ready = 1'b0;
  endtask

  task automatic test_coalesce();
    logic [1:0]  f [3];
    logic [10:0] e [3];
    int          n_exp;
    logic [1:0]  xf [3];
    logic [10:0] xe [3];
    f = '{2'd0, 2'd0, 2'd1};
    e = '{11'd7, 11'd7, 11'd7};
`ifdef IMSIC_MSI_COALESCE_EN
    n_exp = 2;
    xf = '{2'd0, 2'd1, 2'd0};
    xe = '{11'd7, 11'd7, 11'd0};
`else
    n_exp = 3;
    xf = '{2'd0, 2'd0, 2'd1};
    xe = '{11'd7, 11'd7, 11'd7};
`endif
    setip_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      msi_valid = 1'b1; msi_file = f[k]; msi_eiid = e[k];
      tick();
    end
    msi_valid = 1'b0;
    tests++; if (occ !== 3'(n_exp)) begin fails++; $display("FAIL coal_occ got %0d exp %0d", occ, n_exp); end
    tests++; if (drop_cnt !== 16'd0) begin fails++; $display("FAIL coal_drop got %0d exp 0", drop_cnt); end
    setip_ready = 1'b1;
    for (int k = 0; k < n_exp; k++) begin
      #1;
      tests++; if (setip_file !== xf[k]) begin fails++; $display("FAIL coal_file k%0d got %0d exp %0d", k, setip_file, xf[k]); end
      tests++; if (setip_eiid !== xe[k]) begin fails++; $display("FAIL coal_eiid k%0d got %0d exp %0d", k, setip_eiid, xe[k]); end
      tick();
    end
    tests++; if (setip_valid !== 1'b0) begin fails++; $display("FAIL coal_empty got %b exp 0", setip_valid); end
    setip_ready = 1'b0;
  endtask

  task automatic test_mid_reset();
    setip_ready = 1'b0; msi_file = 2'd1;
    for (int k = 0; k < 3; k++) begin
      msi_valid = 1'b1; msi_eiid = 11'(30 + k);
      tick();
    end
    msi_valid = 1'b0; rst_ni = 1'b0;
    tick();
    rst_ni = 1'b1; setip_ready = 1'b1;
    tests++; if (occ !== 3'd0) begin fails++; $display("FAIL midrst_occ got %0d exp 0", occ); end
    tick();
    tests++; if (setip_valid !== 1'b0) begin fails++; $display("FAIL midrst_valid got %b exp 0", setip_valid); end
    setip_ready = 1'b0;
  endtask

  initial begin
    test_reset();
    test_single();
    test_full();
    test_illegal();
    test_back_to_back();
    test_coalesce();
    test_mid_reset();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
